// File: rtl/shift_unit_if.sv
// Request/response bundle for the multi-cycle shift unit.
// slave: the shift unit itself; master: whoever issues shifts and takes results.
interface shift_unit_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH) + 1
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry, busy
  );

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry, busy
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Iterative shift unit: shifts by up to STEP bits per cycle until the
// requested amount is consumed, then holds result + carry until taken.
// Modes: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
// Build option: SHIFT_UNIT_ROTATE_EN enables the rotate datapath; without
// it mode 11 is an alias of LSL (same result, carry and latency).
module shift_unit_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 6,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          rst,
  shift_unit_if.slave  io
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;       // operand being shifted
  logic [AMT_W-1:0] rem_q, rem_d;         // bits still to shift
  logic [1:0]       mode_q, mode_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] out_data_q, out_data_d; // only written on entry to DONE

  logic [AMT_W-1:0]   k;
  logic [WIDTH:0]     lsl_ext;  // {carry, data}
  logic [WIDTH:0]     lsr_ext;  // {data, carry}
  logic signed [WIDTH:0] asr_ext;
  logic [WIDTH-1:0]   step_data;
  logic               step_carry;

  // One step of the datapath: k = min(remaining, STEP). The extra bit on the
  // extended vectors catches the last bit moved out, which is the carry.
  always_comb begin
    k          = (rem_q > AMT_W'(STEP)) ? AMT_W'(STEP) : rem_q;
    lsl_ext    = {1'b0, work_q} << k;
    lsr_ext    = {work_q, 1'b0} >> k;
    asr_ext    = $signed({work_q, 1'b0}) >>> k;
    step_data  = lsl_ext[WIDTH-1:0];
    step_carry = lsl_ext[WIDTH];
    case (mode_q)
      2'b01: begin
        step_data  = lsr_ext[WIDTH:1];
        step_carry = lsr_ext[0];
      end
      2'b10: begin
        step_data  = asr_ext[WIDTH:1];
        step_carry = asr_ext[0];
      end
`ifdef SHIFT_UNIT_ROTATE_EN
      2'b11: begin
        // k == WIDTH gives work_q >> 0 on the wrap side: a full rotation.
        step_data  = lsl_ext[WIDTH-1:0] | (work_q >> (AMT_W'(WIDTH) - k));
        step_carry = lsl_ext[WIDTH];
      end
`else
      2'b11: begin
        step_data  = lsl_ext[WIDTH-1:0];
        step_carry = lsl_ext[WIDTH];
      end
`endif
      default: begin
        step_data  = lsl_ext[WIDTH-1:0];
        step_carry = lsl_ext[WIDTH];
      end
    endcase
  end

  // Next-state logic: accept in IDLE, iterate in SHIFT, hold in DONE.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    carry_d    = carry_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          work_d  = io.in_data;
          rem_d   = io.in_amt;
          mode_d  = io.in_mode;
          carry_d = 1'b0;
          if (io.in_amt == '0) begin
            out_data_d = io.in_data;
            state_d    = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d  = step_data;
        carry_d = step_carry;
        rem_d   = rem_q - k;
        if (rem_q == k) begin
          out_data_d = step_data;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      rem_q      <= '0;
      mode_q     <= '0;
      carry_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      carry_q    <= carry_d;
      out_data_q <= out_data_d;
    end
  end

  // Status outputs decoded straight from state; in_ready drops during reset.
  always_comb begin
    io.in_ready  = (state_q == S_IDLE) && !rst;
    io.out_valid = (state_q == S_DONE);
    io.busy      = (state_q != S_IDLE);
    io.out_data  = out_data_q;
    io.out_carry = carry_q;
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq (WIDTH=16, STEP=6): directed vectors, backpressure,
// input isolation, mid-shift reset, then random requests against a bit-serial
// reference model.
module tb_shift_unit_seq;
  localparam int W = 16;
  localparam int S = 6;
  localparam int A = $clog2(W) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tot = 0, n_pass = 0, n_fail = 0;

  shift_unit_if #(.WIDTH(W)) bus ();
  shift_unit_seq #(.WIDTH(W), .STEP(S)) dut (.clk(clk), .rst(rst), .io(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: shift one bit at a time, amt times.
  function automatic void model(input logic [W-1:0] d, input int amt, input logic [1:0] m,
                                output logic [W-1:0] r, output logic c, output int lat);
    logic [1:0] mm = m;
`ifndef SHIFT_UNIT_ROTATE_EN
    if (mm == 2'b11) mm = 2'b00;
`endif
    r = d; c = 1'b0;
    for (int i = 0; i < amt; i++) begin
      case (mm)
        2'b00: begin c = r[W-1]; r = {r[W-2:0], 1'b0}; end
        2'b01: begin c = r[0];   r = {1'b0, r[W-1:1]}; end
        2'b10: begin c = r[0];   r = {r[W-1], r[W-1:1]}; end
        default: begin r = {r[W-2:0], r[W-1]}; c = r[0]; end
      endcase
    end
    lat = 1 + (amt + S - 1) / S;
  endfunction

  // Issue one request and wait (bounded) for out_valid; scramble inputs while busy.
  task automatic issue(input logic [W-1:0] d, input int amt, input logic [1:0] m,
                       output logic [W-1:0] od, output logic oc, output int lat);
    int g = 0;
    while (!bus.in_ready && g < 50) begin @(posedge clk); #1; g++; end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_data = d; bus.in_amt = A'(amt); bus.in_mode = m; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    bus.in_amt   = A'($urandom);
    bus.in_mode  = 2'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1; lat++;
      bus.in_data = W'($urandom); bus.in_amt = A'($urandom);
    end
    od = bus.out_data; oc = bus.out_carry;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("post_hs_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic vec(input logic [W-1:0] d, input int amt, input logic [1:0] m,
                     input logic [W-1:0] ed, input logic ec, input int el);
    logic [W-1:0] od; logic oc; int lat;
    issue(d, amt, m, od, oc, lat);
    chk("data", 32'(od), 32'(ed));
    chk("carry", 32'(oc), 32'(ec));
    chk("latency", 32'(lat), 32'(el));
    release_out();
  endtask

  initial begin
    logic [W-1:0] od, md, hd; logic oc, mc, hc; int lat, ml, seen;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_mode = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_carry", 32'(bus.out_carry), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors with hand-derived expectations
    vec(16'h1234, 6,  2'b00, 16'h8D00, 1'b0, 2);
    vec(16'hABCD, 1,  2'b01, 16'h55E6, 1'b1, 2);
    vec(16'hABCD, 0,  2'b01, 16'hABCD, 1'b0, 1);
    vec(16'h8000, 15, 2'b10, 16'hFFFF, 1'b0, 4);
    vec(16'hFFFF, 16, 2'b00, 16'h0000, 1'b1, 4);
    vec(16'hFFFF, 17, 2'b00, 16'h0000, 1'b0, 4);
    vec(16'h8001, 16, 2'b01, 16'h0000, 1'b1, 4);
`ifdef SHIFT_UNIT_ROTATE_EN
    vec(16'h8001, 4,  2'b11, 16'h0018, 1'b0, 2);
    vec(16'h8001, 20, 2'b11, 16'h0018, 1'b0, 5);
`else
    vec(16'h8001, 4,  2'b11, 16'h0010, 1'b0, 2);
    vec(16'h8001, 20, 2'b11, 16'h0000, 1'b0, 5);
`endif

    // Backpressure: result held, in_ready low; inputs scrambled during SHIFT
    issue(16'hC3A5, 13, 2'b10, od, oc, lat);
    model(16'hC3A5, 13, 2'b10, md, mc, ml);
    chk("bp_data", 32'(od), 32'(md));
    chk("bp_carry", 32'(oc), 32'(mc));
    hd = od; hc = oc;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.out_data), 32'(hd));
      chk("bp_hold_carry", 32'(bus.out_carry), 32'(hc));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    release_out();

    // Reset during SHIFT discards the request
    bus.in_data = 16'h8000; bus.in_amt = A'(15); bus.in_mode = 2'b10; bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_carry", 32'(bus.out_carry), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0; #1;
    chk("mid_rel_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("mid_no_valid", 32'(seen), 32'd0);
    vec(16'h1234, 6, 2'b00, 16'h8D00, 1'b0, 2);

    // Random requests against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] d; int a; logic [1:0] m;
      d = W'($urandom); a = $urandom_range(0, 31); m = 2'($urandom);
      model(d, a, m, md, mc, ml);
      vec(d, a, m, md, mc, ml);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/shift_unit_seq.md
# shift_unit_seq

Parametrised multi-cycle shift unit for the Double Accumulator Processor datapath, generalising the fixed 1-bit and 6-bit left shifters. It takes an operand, a shift amount and a mode through a valid/ready handshake, and shifts iteratively by up to `STEP` bits per cycle. It returns the result plus the last bit shifted out (carry) through a held output handshake, so the accumulator can stall on it.

## Interface

Parameters:

- `WIDTH`, 16: operand/result width, ≥ 2.
- `STEP`, 6: maximum bits shifted per cycle, 1..`WIDTH`.
- `AMT_W`, `$clog2(WIDTH)+1`: shift-amount width, derived; do not override.

Ports:

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request.
- `in_data` in `WIDTH`: operand.
- `in_amt` in `AMT_W`: shift amount, 0..2^`AMT_W`-1.
- `in_mode` in 2: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `out_data` out `WIDTH`: result.
- `out_carry` out 1: last bit shifted or rotated out; 0 when `in_amt`=0.
- `busy` out 1: high in SHIFT and DONE.

## Operation

- States: IDLE, SHIFT, DONE.
- `in_ready` = (state==IDLE) && !`rst`.
- Accept occurs on a rising edge with `in_valid`&&`in_ready`:
  - Load the operand, amount and mode.
  - Clear the carry.
  - Go to SHIFT if amt>0, else go to DONE.
- SHIFT, per edge:
  - k = min(remaining, `STEP`); apply a k-bit shift in the latched mode; remaining -= k.
  - Carry = last bit moved out in this step.
  - Go to DONE when remaining reaches 0.
- Modes:
  - LSL: zero fill.
  - LSR: zero fill.
  - ASR: replicate the original MSB.
  - ROL: bits leaving the MSB re-enter at the LSB; carry = result bit 0.
- Amount ≥ `WIDTH` is legal and needs no special casing:
  - LSL/LSR: result 0; carry = 0 if amt > `WIDTH`, else the last original edge bit.
  - ASR: result is all sign bits.
  - ROL: effective rotate by amt mod `WIDTH`.
- DONE:
  - `out_valid`=1 with `out_data`/`out_carry` held stable.
  - On an edge with `out_ready`=1, go to IDLE.
- Inputs are ignored while not IDLE. The latched copies are used, so input changes mid-operation have no effect.

## Timing

- Reset values: `out_valid`=0, `out_data`=0, `out_carry`=0, `busy`=0, state IDLE. `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Latency from the accept edge to `out_valid` high: 1 + ceil(amt/`STEP`) edges. amt=0 → 1, a pass-through with carry 0.
- The result is held indefinitely under backpressure (`out_ready`=0). `in_ready` stays low throughout.
- There is no bypass. After the output handshake edge, `in_ready`=1 in the next cycle, so the minimum issue interval is latency + 1.
- `rst` asserted in any state forces reset values immediately. The in-flight request is discarded and no `out_valid` is produced for it.
- `out_data` is undefined-free: it retains its last value in IDLE and SHIFT and is updated only on transitions into DONE.

## Configuration

- Macro: `SHIFT_UNIT_ROTATE_EN`.
- Defined: mode 11 performs ROL as above.
- Undefined:
  - The rotate datapath is not compiled.
  - Mode 11 behaves exactly as LSL: same result, carry and latency.

## Test plan

Defaults: `WIDTH`=16, `STEP`=6.

- LSL 0x1234, amt 6 → `out_data`=0x8D00, carry 0, `out_valid` 2 edges after accept.
- LSR 0xABCD, amt 1 → 0x55E6, carry 1, latency 2. Same operand with amt 0 → 0xABCD, carry 0, latency 1.
- ASR 0x8000, amt 15 → 0xFFFF, carry 0, latency 4. LSL 0xFFFF, amt 16 → 0x0000, carry 1, latency 4. LSL 0xFFFF, amt 17 → 0x0000, carry 0.
- Mode 11, 0x8001, amt 4:
  - With `SHIFT_UNIT_ROTATE_EN` → 0x0018, carry 0.
  - Without → 0x0010, carry 0.
- Backpressure and input isolation:
  - Hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, `out_data` and `out_carry` stable and `in_ready`=0 throughout.
  - Change `in_data`/`in_amt` during SHIFT → no effect on the result.
- Reset mid-SHIFT (amt 15, `rst` pulsed on cycle 2) → outputs at reset values immediately, no `out_valid` for that request. `in_ready`=1 on the cycle after release, and the next request completes normally.
